eth_frame_loop_sched: RTL and testbench

ETH_FRAME_LOOP_SCHED -- requirements
Module: eth_frame_loop_sched

---
 rtl/eth_frame_loop_sched.sv | 154 +++++++++++++++
 tb/tb_eth_frame_loop_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_loop_sched.sv
// Frame scheduler: takes one control entry per frame, then forwards or discards the
// frame bytes, optionally overwriting a 16-bit checksum at a given byte offset.
module eth_frame_loop_sched #(
   parameter int C_DROP_FCS_INVALID = 1,
   parameter int C_CNT_WIDTH        = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [39:0]            s_axis_ctl_tdata,
   input  logic                   s_axis_ctl_tvalid,
   output logic                   s_axis_ctl_tready,
   input  logic [7:0]             s_axis_frame_tdata,
   input  logic                   s_axis_frame_tlast,
   input  logic                   s_axis_frame_tvalid,
   output logic                   s_axis_frame_tready,
   output logic [7:0]             m_axis_tdata,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [C_CNT_WIDTH-1:0] count_tx,
   output logic [C_CNT_WIDTH-1:0] count_drop,
   output logic                   busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FORWARD = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [15:0]            byte_idx_r;
   logic [15:0]            csum_val_r;
   logic [14:0]            csum_pos_r;
   logic [C_CNT_WIDTH-1:0] count_tx_r;
   logic [C_CNT_WIDTH-1:0] count_drop_r;
   logic                   ctl_hs_s;
   logic                   frame_hs_s;
   logic                   discard_sel_s;
   logic                   csum_hi_hit_s;
   logic                   csum_lo_hit_s;
   logic                   ctl_unused_s;

   function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v);
      if (v == {C_CNT_WIDTH{1'b1}}) begin
         sat_inc = v;
      end else begin
         sat_inc = v + {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   endfunction

   assign ctl_unused_s  = ^s_axis_ctl_tdata[39:33];
   assign ctl_hs_s      = s_axis_ctl_tvalid & s_axis_ctl_tready;
   assign frame_hs_s    = s_axis_frame_tvalid & s_axis_frame_tready;
   assign discard_sel_s = s_axis_ctl_tdata[1] |
                          (s_axis_ctl_tdata[0] & (C_DROP_FCS_INVALID != 0));
   // A zero position disables substitution; the low byte compare is 16 bits wide so pos+1 never wraps.
   assign csum_hi_hit_s = (csum_pos_r != 15'd0) && (byte_idx_r == {1'b0, csum_pos_r});
   assign csum_lo_hit_s = (csum_pos_r != 15'd0) && (byte_idx_r == ({1'b0, csum_pos_r} + 16'd1));
   assign busy          = (state_r != ST_IDLE);
   assign count_tx      = count_tx_r;
   assign count_drop    = count_drop_r;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ctl_hs_s) begin
               state_nxt_s = discard_sel_s ? ST_DISCARD : ST_FORWARD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FORWARD, ST_DISCARD: begin
            if (frame_hs_s && s_axis_frame_tlast) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Handshake and output data steering
   always_comb begin
      s_axis_ctl_tready   = 1'b0;
      s_axis_frame_tready = 1'b0;
      m_axis_tvalid       = 1'b0;
      m_axis_tlast        = 1'b0;
      m_axis_tdata        = s_axis_frame_tdata;
      case (state_r)
         ST_IDLE: begin
            s_axis_ctl_tready = enable;
         end
         ST_FORWARD: begin
            m_axis_tvalid       = s_axis_frame_tvalid;
            s_axis_frame_tready = m_axis_tready;
            m_axis_tlast        = s_axis_frame_tlast;
            if (csum_hi_hit_s) begin
               m_axis_tdata = csum_val_r[15:8];
            end else if (csum_lo_hit_s) begin
               m_axis_tdata = csum_val_r[7:0];
            end else begin
               m_axis_tdata = s_axis_frame_tdata;
            end
         end
         ST_DISCARD: begin
            s_axis_frame_tready = 1'b1;
         end
         default: begin
            s_axis_ctl_tready = 1'b0;
         end
      endcase
   end

   // Control latch, byte index and frame statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx_r   <= 16'd0;
         csum_val_r   <= 16'd0;
         csum_pos_r   <= 15'd0;
         count_tx_r   <= {C_CNT_WIDTH{1'b0}};
         count_drop_r <= {C_CNT_WIDTH{1'b0}};
      end else if (ctl_hs_s) begin
         csum_val_r <= s_axis_ctl_tdata[32:17];
         csum_pos_r <= s_axis_ctl_tdata[16:2];
         byte_idx_r <= 16'd0;
      end else if (frame_hs_s) begin
         if (byte_idx_r != 16'hFFFF) begin
            byte_idx_r <= byte_idx_r + 16'd1;
         end
         if (s_axis_frame_tlast && (state_r == ST_FORWARD)) begin
            count_tx_r <= sat_inc(count_tx_r);
         end
         if (s_axis_frame_tlast && (state_r == ST_DISCARD)) begin
            count_drop_r <= sat_inc(count_drop_r);
         end
      end
   end

endmodule

// File: tb/tb_eth_frame_loop_sched.sv
// Randomized bench for eth_frame_loop_sched: a default instance plus a forwarding-on-FCS
// instance with 4-bit counters, both driven by the same stimulus.
module tb_eth_frame_loop_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [39:0] ctl_tdata;
   logic        ctl_tvalid;
   logic        ctl_tready, ctl_tready_b;
   logic [7:0]  frame_tdata;
   logic        frame_tlast, frame_tvalid;
   logic        frame_tready, frame_tready_b;
   logic [7:0]  m_tdata, m_tdata_b;
   logic        m_tlast, m_tlast_b, m_tvalid, m_tvalid_b;
   logic        m_tready;
   logic [31:0] count_tx, count_drop;
   logic [3:0]  count_tx_b, count_drop_b;
   logic        busy, busy_b;

   int n_chk  = 0;
   int n_pass = 0;
   int n_tx_a = 0, n_drop_a = 0, n_tx_b = 0, n_drop_b = 0;

   always #5 clk = ~clk;

   eth_frame_loop_sched dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .s_axis_ctl_tdata(ctl_tdata), .s_axis_ctl_tvalid(ctl_tvalid), .s_axis_ctl_tready(ctl_tready),
      .s_axis_frame_tdata(frame_tdata), .s_axis_frame_tlast(frame_tlast),
      .s_axis_frame_tvalid(frame_tvalid), .s_axis_frame_tready(frame_tready),
      .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .count_tx(count_tx), .count_drop(count_drop), .busy(busy)
   );

   eth_frame_loop_sched #(.C_DROP_FCS_INVALID(0), .C_CNT_WIDTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .s_axis_ctl_tdata(ctl_tdata), .s_axis_ctl_tvalid(ctl_tvalid), .s_axis_ctl_tready(ctl_tready_b),
      .s_axis_frame_tdata(frame_tdata), .s_axis_frame_tlast(frame_tlast),
      .s_axis_frame_tvalid(frame_tvalid), .s_axis_frame_tready(frame_tready_b),
      .m_axis_tdata(m_tdata_b), .m_axis_tlast(m_tlast_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_tready),
      .count_tx(count_tx_b), .count_drop(count_drop_b), .busy(busy_b)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: byte idx of a frame with checksum (pos,val); pos 0 means no substitution.
   function automatic logic [7:0] exp_byte(input int idx, input logic [7:0] b, input int pos,
                                           input logic [15:0] val);
      if (pos != 0 && idx == pos)          return val[15:8];
      else if (pos != 0 && idx == pos + 1) return val[7:0];
      else                                 return b;
   endfunction

   function automatic int sat4(input int n);
      return (n > 15) ? 15 : n;
   endfunction

   task automatic check_counts(input string tag);
      check_val({tag, "_tx"},     count_tx,   n_tx_a);
      check_val({tag, "_drop"},   count_drop, n_drop_a);
      check_val({tag, "_tx_b"},   {28'd0, count_tx_b},   sat4(n_tx_b));
      check_val({tag, "_drop_b"}, {28'd0, count_drop_b}, sat4(n_drop_b));
   endtask

   task automatic run_frame(input logic [15:0] cval, input logic [14:0] cpos, input logic drop,
                            input logic fcs, input int len, input int bp_in,
                            input int en_off_at, input int rst_at);
      int          i;
      int          wait_c;
      int          bp;
      logic [7:0]  b;
      logic        fwd_a, fwd_b, aborted;
      fwd_a   = !drop && !fcs;
      fwd_b   = !drop;
      bp      = (fcs && !drop) ? 0 : bp_in;
      aborted = 1'b0;
      b       = 8'($urandom);

      @(negedge clk);
      ctl_tvalid   = 1'b1;
      ctl_tdata    = {7'd0, cval, cpos, drop, fcs};
      frame_tvalid = 1'b1;
      frame_tdata  = b;
      frame_tlast  = (len == 1);
      m_tready     = 1'b1;
      #1;
      check_val("idle_frame_rdy", frame_tready, 0);
      check_val("idle_m_valid", m_tvalid, 0);
      wait_c = 0;
      while (!ctl_tready && wait_c < 20) begin
         @(negedge clk);
         wait_c++;
         #1;
      end
      check_val("ctl_accept_timeout", (wait_c < 20), 1);

      i      = 0;
      wait_c = 0;
      while (i < len && wait_c < 1000) begin
         @(negedge clk);
         ctl_tvalid = 1'b0;
         if (i == en_off_at) enable = 1'b0;
         m_tready     = (bp == 0) ? 1'b1 : ($urandom_range(99) >= 32'(bp));
         frame_tdata  = b;
         frame_tlast  = (i == len - 1);
         frame_tvalid = 1'b1;
         #1;
         if (i == rst_at) begin
            rst_n = 1'b0;
            #1;
            check_val("rst_busy", busy, 0);
            check_val("rst_m_valid", m_tvalid, 0);
            check_val("rst_frame_rdy", frame_tready, 0);
            n_tx_a = 0; n_drop_a = 0; n_tx_b = 0; n_drop_b = 0;
            check_counts("rst_cnt");
            aborted = 1'b1;
            break;
         end
         if (i == 0 && wait_c == 0) begin
            check_val("ctl_rdy_in_frame", ctl_tready, 0);
            check_val("busy_in_frame", busy, 1);
         end
         if (fwd_a) begin
            check_val("fwd_valid", m_tvalid, 1);
            check_val("fwd_frame_rdy", frame_tready, m_tready);
            if (m_tready) begin
               check_val("fwd_data", m_tdata, exp_byte(i, b, int'(cpos), cval));
               check_val("fwd_last", m_tlast, (i == len - 1));
            end
         end else begin
            check_val("drop_valid", m_tvalid, 0);
            check_val("drop_frame_rdy", frame_tready, 1);
         end
         if (fwd_b && !fwd_a) begin
            check_val("fcs_fwd_valid_b", m_tvalid_b, 1);
            check_val("fcs_fwd_data_b", m_tdata_b, exp_byte(i, b, int'(cpos), cval));
            check_val("fcs_fwd_last_b", m_tlast_b, (i == len - 1));
         end
         if (frame_tready) begin
            i++;
            b      = 8'($urandom);
            wait_c = 0;
         end else begin
            wait_c++;
         end
      end

      if (aborted) begin
         @(negedge clk);
         rst_n = 1'b1;
         repeat (3) begin
            @(negedge clk);
            #1;
            check_val("post_rst_no_consume", frame_tready, 0);
            check_val("post_rst_busy", busy, 0);
         end
      end else begin
         check_val("frame_timeout", (wait_c < 1000), 1);
         @(negedge clk);
         frame_tvalid = 1'b0;
         #1;
         if (fwd_a) n_tx_a++; else n_drop_a++;
         if (fwd_b) n_tx_b++; else n_drop_b++;
         check_counts("end_cnt");
         check_val("end_busy", busy, 0);
      end

      if (en_off_at >= 0) begin
         repeat (5) begin
            @(negedge clk);
            ctl_tvalid = 1'b1;
            #1;
            check_val("en_off_ctl_rdy", ctl_tready, 0);
            check_val("en_off_busy", busy, 0);
         end
         @(negedge clk);
         ctl_tvalid = 1'b0;
         enable     = 1'b1;
      end
   endtask

   initial begin
      int          len;
      logic [14:0] cpos;
      logic        drop, fcs;
      rst_n        = 1'b0;
      enable       = 1'b0;
      ctl_tdata    = 40'd0;
      ctl_tvalid   = 1'b0;
      frame_tdata  = 8'd0;
      frame_tlast  = 1'b0;
      frame_tvalid = 1'b0;
      m_tready     = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_val("reset_busy", busy, 0);
      check_val("reset_m_valid", m_tvalid, 0);
      check_val("reset_frame_rdy", frame_tready, 0);
      check_val("reset_ctl_rdy", ctl_tready, 0);
      check_counts("reset_cnt");
      @(negedge clk);
      rst_n  = 1'b1;
      enable = 1'b1;

      run_frame(16'h0000, 15'd0,  1'b0, 1'b0, 64, 0, -1, -1);
      run_frame(16'hBEEF, 15'd40, 1'b0, 1'b0, 64, 0, -1, -1);
      run_frame(16'h1234, 15'd5,  1'b1, 1'b0, 60, 0, -1, -1);
      run_frame(16'h0000, 15'd0,  1'b0, 1'b1, 60, 0, -1, -1);
      run_frame(16'hA55A, 15'd9,  1'b0, 1'b0, 10, 0, -1, -1);
      run_frame(16'hC3C3, 15'd1,  1'b0, 1'b0, 1,  0, -1, -1);
      run_frame(16'h0000, 15'd0,  1'b0, 1'b0, 64, 0, 10, -1);

      for (int k = 0; k < 100; k++) begin
         len  = int'($urandom_range(80, 1));
         cpos = ($urandom_range(3) == 0) ? 15'd0 : 15'($urandom_range(len + 1, 1));
         run_frame(16'($urandom), cpos, 1'b0, 1'b0, len, 50, -1, -1);
      end

      for (int k = 0; k < 20; k++) begin
         len  = int'($urandom_range(40, 1));
         drop = ($urandom_range(3) == 0);
         fcs  = ($urandom_range(2) == 0);
         cpos = 15'($urandom_range(len + 1, 0));
         run_frame(16'($urandom), cpos, drop, fcs, len, 0, -1, -1);
      end

      run_frame(16'h0000, 15'd0, 1'b0, 1'b0, 64, 0, -1, 20);
      run_frame(16'h5AA5, 15'd3, 1'b0, 1'b0, 16, 30, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
